alien_hit_detector: RTL

ALIEN_HIT_DETECTOR -- requirements
Module: alien_hit_detector

---
 rtl/alien_hit_detector_pkg.sv | 35 +++
 rtl/alien_hit_detector_hitbox_check.sv | 19 +
 rtl/alien_hit_detector.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/alien_hit_detector_pkg.sv
// Shared game constants: screen size, laser park position, formation defaults, row scoring.
// No logic of its own. Used by the hit detector and the laser stage.
// No flow control.
package alien_hit_detector_pkg;

    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;

    // The laser stage parks an idle shot at the bottom-right pixel
    localparam logic [9:0] LASER_PARK_X = 10'(SCREEN_WIDTH - 1);
    localparam logic [9:0] LASER_PARK_Y = 10'(SCREEN_HEIGHT - 1);

    localparam int DEF_ROWS = 5;
    localparam int DEF_COLS = 8;

    localparam logic [15:0] ROW_PTS_TOP = 16'd30;
    localparam logic [15:0] ROW_PTS_MID = 16'd20;
    localparam logic [15:0] ROW_PTS_LOW = 16'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        KILL = 2'd2
    } scan_state_t;

    function automatic logic [15:0] row_points(input int row);
        if (row == 0)
            return ROW_PTS_TOP;
        else if (row <= 2)
            return ROW_PTS_MID;
        else
            return ROW_PTS_LOW;
    endfunction

endpackage

// File: rtl/alien_hit_detector_hitbox_check.sv
// Point-in-box test with half-open extents: bx <= px < bx+bw, by <= py < by+bh.
// Purely combinational, zero latency.
// No flow control.
module hitbox_check #(
    parameter int W = 11
) (
    input  logic [W-1:0] px,
    input  logic [W-1:0] py,
    input  logic [W-1:0] bx,
    input  logic [W-1:0] by,
    input  logic [W-1:0] bw,
    input  logic [W-1:0] bh,
    output logic         hit
);

    assign hit = (px >= bx) && (px < bx + bw) &&
                 (py >= by) && (py < by + bh);

endmodule

// File: rtl/alien_hit_detector.sv
// Sequential laser-vs-formation hit test; one alien per clock, first hit kills and scores.
// Latency: tick to kill visible is at most ROWS*COLS+2 cycles.
// No backpressure; ticks must be spaced at least ROWS*COLS+2 cycles apart.
module alien_hit_detector
    import alien_hit_detector_pkg::*;
#(
    parameter int ROWS    = DEF_ROWS,
    parameter int COLS    = DEF_COLS,
    parameter int CELL_W  = 48,
    parameter int CELL_H  = 32,
    parameter int ALIEN_W = 32,
    parameter int ALIEN_H = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 newWave,
    input  logic [9:0]           xLaser,
    input  logic [9:0]           yLaser,
    input  logic [9:0]           xAliens,
    input  logic [9:0]           yAliens,
    output logic                 killingAlien,
    output logic [ROWS*COLS-1:0] aliveMask,
    output logic [15:0]          score,
    output logic                 allDead
);

    localparam int N  = ROWS * COLS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    scan_state_t   state;
    logic [N-1:0]  alive_q;
    logic [15:0]   score_q;
    logic          killing_q;
    logic [IW-1:0] idx;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [10:0]   ax_q;
    logic [10:0]   ay_q;
    logic [10:0]   x0_q;
    logic [10:0]   lx_q;
    logic [10:0]   ly_q;
    logic [IW-1:0] hit_idx;
    logic [RW-1:0] hit_row;
    logic          box_hit;
    logic          parked;
    logic [15:0]   pts;
    logic [16:0]   score_sum;

    hitbox_check #(.W(11)) u_hitbox (
        .px  (lx_q),
        .py  (ly_q),
        .bx  (ax_q),
        .by  (ay_q),
        .bw  (11'(ALIEN_W)),
        .bh  (11'(ALIEN_H)),
        .hit (box_hit)
    );

    assign parked = (xLaser == LASER_PARK_X) && (yLaser == LASER_PARK_Y);

    always_comb begin
        pts       = row_points(int'(hit_row));
        score_sum = {1'b0, score_q} + {1'b0, pts};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            alive_q   <= '1;
            score_q   <= '0;
            killing_q <= 1'b0;
            idx       <= '0;
            col       <= '0;
            row       <= '0;
            ax_q      <= '0;
            ay_q      <= '0;
            x0_q      <= '0;
            lx_q      <= '0;
            ly_q      <= '0;
            hit_idx   <= '0;
            hit_row   <= '0;
        end else if (newWave) begin
            alive_q   <= '1;
            killing_q <= 1'b0;
            state     <= IDLE;
        end else begin
            // Any tick consumes the flag; a kill landing on the same cycle re-asserts it below
            if (enable)
                killing_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (enable && !parked && (alive_q != '0)) begin
                        lx_q  <= {1'b0, xLaser};
                        ly_q  <= {1'b0, yLaser};
                        x0_q  <= {1'b0, xAliens};
                        ax_q  <= {1'b0, xAliens};
                        ay_q  <= {1'b0, yAliens};
                        idx   <= '0;
                        col   <= '0;
                        row   <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (alive_q[idx] && box_hit) begin
                        hit_idx <= idx;
                        hit_row <= row;
                        state   <= KILL;
                    end else if (idx == IW'(N - 1)) begin
                        state <= IDLE;
                    end else begin
                        idx <= idx + IW'(1);
                        // Box origin walks with the index instead of being multiplied out
                        if (col == CW'(COLS - 1)) begin
                            col  <= '0;
                            row  <= row + RW'(1);
                            ax_q <= x0_q;
                            ay_q <= ay_q + 11'(CELL_H);
                        end else begin
                            col  <= col + CW'(1);
                            ax_q <= ax_q + 11'(CELL_W);
                        end
                    end
                end
                KILL: begin
                    alive_q[hit_idx] <= 1'b0;
                    killing_q        <= 1'b1;
                    score_q          <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign aliveMask    = alive_q;
    assign score        = score_q;
    assign killingAlien = killing_q;
    assign allDead      = (alive_q == '0);

endmodule
